// File: rtl/maxdiff_pkg.sv
// maxdiff_pkg
//   Shared constants and arithmetic helpers for the maxdiff datapath.
//   MODE_WRAP / MODE_SAT select the overflow behaviour of every operation.
//   sat_sub / sat_add operate on MAX_W-bit operands so one definition serves
//   any datapath width up to MAX_W. Both return {ovf, result}.
package maxdiff_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  localparam int MAX_W = 32;

  // x - y. Underflow (y > x) flags ovf; the result is either clamped to 0 or
  // left as the two's-complement difference, whose low W bits are the
  // modulo-2^W answer for any W <= MAX_W.
  function automatic logic [MAX_W:0] sat_sub(input logic [MAX_W-1:0] x,
                                             input logic [MAX_W-1:0] y,
                                             input logic             sat);
    logic [MAX_W-1:0] res;
    logic             ovf;
    ovf = (y > x);
    res = x - y;
    if (ovf && sat) res = '0;
    return {ovf, res};
  endfunction

  // x + y for w-bit operands. A sum reaching 2^w flags ovf and is either
  // clamped to 2^w-1 or reduced modulo 2^w.
  function automatic logic [MAX_W:0] sat_add(input logic [MAX_W-1:0] x,
                                             input logic [MAX_W-1:0] y,
                                             input int               w,
                                             input logic             sat);
    logic [MAX_W:0] sum;
    logic [MAX_W:0] lim;
    logic           ovf;
    sum = {1'b0, x} + {1'b0, y};
    lim = {{MAX_W{1'b0}}, 1'b1} << w;
    ovf = (sum >= lim);
    if (ovf) sum = sat ? (lim - 1'b1) : (sum - lim);
    return {ovf, sum[MAX_W-1:0]};
  endfunction

endpackage

// File: rtl/maxdiff_pipe_absmax.sv
// absmax_stage
//   Combinational max(a,b) and |a-b| on unsigned operands; equal operands
//   give ad = 0.
// Ports
//   a, b  in  W  operands
//   mx    out W  larger operand
//   ad    out W  absolute difference
module absmax_stage
  import maxdiff_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] mx,
  output logic [W-1:0] ad
);

  always_comb begin
    mx = a;
    ad = '0;
    if (a >= b) begin
      mx = a;
      ad = a - b;
    end else begin
      mx = b;
      ad = b - a;
    end
  end

endmodule

// File: rtl/maxdiff_pipe.sv
// maxdiff_pipe
//   Three-stage valid/ready pipeline computing
//     out = max(a,b) + max(floor, bias - K*|a-b|)
//   with either wrapping or saturating arithmetic (SAT). Bias and floor are
//   captured with each transaction. out_ovf reports that any operation of the
//   transaction wrapped or saturated.
//   W must not exceed maxdiff_pkg::MAX_W.
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     input handshake
//   in_a, in_b            operands
//   cfg_bias, cfg_floor   per-transaction bias and floor
//   out_valid/out_ready   output handshake
//   out_data, out_ovf     result and overflow flag
//   busy                  any stage holds a transaction
//   count                 completed output transfers (wraps)
module maxdiff_pipe
  import maxdiff_pkg::*;
#(
  parameter int W     = 8,
  parameter int K     = 5,
  parameter int SAT   = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [W-1:0]     cfg_bias,
  input  logic [W-1:0]     cfg_floor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_ovf,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  localparam logic           SAT_EN = (SAT == MODE_SAT);
  localparam logic [2*W-1:0] K_EXT  = (2*W)'(K);

  // The whole pipe advances as one unit: any stall at the output freezes
  // every stage, so in_ready is simply the output-side advance condition.
  logic adv;

  logic [W-1:0] s1_mx_d, s1_ad_d;

  logic         s1_valid;
  logic [W-1:0] s1_mx, s1_ad, s1_bias, s1_floor;

  logic         s2_valid;
  logic [W-1:0] s2_mx, s2_s;
  logic         s2_ovf;

  logic [2*W-1:0]   prod;
  logic             mul_ovf;
  logic [W-1:0]     pw;
  logic [MAX_W:0]   sub_res;
  logic [W-1:0]     diff;
  logic [W-1:0]     s2_s_d;
  logic             s2_ovf_d;

  logic [MAX_W:0]   add_res;
  logic [W-1:0]     out_data_d;
  logic             out_ovf_d;

  logic             unused_hi;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign busy     = s1_valid || s2_valid || out_valid;

  absmax_stage #(.W(W)) u_absmax (
    .a  (in_a),
    .b  (in_b),
    .mx (s1_mx_d),
    .ad (s1_ad_d)
  );

  // Stage 2 combinational: K*|a-b| at full width, then bias subtraction and
  // floor clamp.
  always_comb begin
    prod     = K_EXT * {{W{1'b0}}, s1_ad};
    mul_ovf  = |prod[2*W-1:W];
    pw       = (mul_ovf && SAT_EN) ? {W{1'b1}} : prod[W-1:0];
    sub_res  = sat_sub(MAX_W'(s1_bias), MAX_W'(pw), SAT_EN);
    diff     = sub_res[W-1:0];
    s2_s_d   = (s1_floor > diff) ? s1_floor : diff;
    s2_ovf_d = mul_ovf || sub_res[MAX_W];
  end

  // Stage 3 combinational: final add.
  always_comb begin
    add_res    = sat_add(MAX_W'(s2_mx), MAX_W'(s2_s), W, SAT_EN);
    out_data_d = add_res[W-1:0];
    out_ovf_d  = s2_ovf || add_res[MAX_W];
  end

  // Upper bits of the shared-width helper results are not needed here.
  assign unused_hi = ^{sub_res, add_res};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_mx     <= '0;
      s1_ad     <= '0;
      s1_bias   <= '0;
      s1_floor  <= '0;
      s2_valid  <= 1'b0;
      s2_mx     <= '0;
      s2_s      <= '0;
      s2_ovf    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      count     <= '0;
    end else begin
      if (adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_mx    <= s1_mx_d;
          s1_ad    <= s1_ad_d;
          s1_bias  <= cfg_bias;
          s1_floor <= cfg_floor;
        end
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_mx  <= s1_mx;
          s2_s   <= s2_s_d;
          s2_ovf <= s2_ovf_d;
        end
        out_valid <= s2_valid;
        if (s2_valid) begin
          out_data <= out_data_d;
          out_ovf  <= out_ovf_d;
        end
      end
      if (out_valid && out_ready) count <= count + CNT_W'(1);
    end
  end

endmodule
